// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks alignment, drives byte-lane accesses on a
// handshaked data bus, stalls the pipeline until completion, returns extended load data.
//
// state  | meaning
// IDLE   | no access in flight; accept an aligned request or flag a misaligned one
// REQ    | bus request presented, waiting for bus_ready
// WAIT   | load accepted by the bus, waiting for bus_rvalid
// DONE   | access complete; pipeline advances, request inputs ignored
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic                  req_sign_ext,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall_req,
  output logic                  bus_en,
  output logic                  bus_we,
  output logic [SEL_WIDTH-1:0]  bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ready,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  addr_err_load,
  output logic                  addr_err_store,
  output logic [ADDR_WIDTH-1:0] bad_vaddr
);

  localparam int OFF_W = $clog2(SEL_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;

  logic [OFF_W-1:0]      off;
  logic                  start, aligned, accept, fault, capture;
  logic [7:0]            mask8;
  logic [SEL_WIDTH-1:0]  sel_d, sel_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic                  we_q, sign_q;
  logic [1:0]            size_q;
  logic [OFF_W-1:0]      off_q;
  logic                  load_valid_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic [DATA_WIDTH-1:0] shifted, keep, ext;
  logic                  sign_bit;

  assign off   = req_addr[OFF_W-1:0];
  assign start = req_valid & (req_read | req_write);

  // Accesses wider than the bus are treated as misaligned.
  always_comb begin
    aligned = 1'b1;
    case (req_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = (off[0] == 1'b0);
      2'd2:    aligned = (SEL_WIDTH >= 4) && (off[1:0] == 2'b00);
      default: aligned = (SEL_WIDTH >= 8) && (off == '0);
    endcase
  end

  assign accept = (state_q == S_IDLE) & start & aligned;
  assign fault  = (state_q == S_IDLE) & start & ~aligned;

  assign addr_err_load  = fault & req_read;
  assign addr_err_store = fault & req_write;
  assign bad_vaddr      = fault ? req_addr : '0;

  always_comb begin
    mask8   = 8'hFF;
    wdata_d = req_wdata;
    case (req_size)
      2'd0: begin
        mask8   = 8'h01;
        wdata_d = {SEL_WIDTH{req_wdata[7:0]}};
      end
      2'd1: begin
        mask8   = 8'h03;
        wdata_d = {(SEL_WIDTH / 2){req_wdata[15:0]}};
      end
      2'd2: begin
        mask8   = 8'h0F;
        wdata_d = {(SEL_WIDTH / 4){req_wdata[31:0]}};
      end
      default: begin
        mask8   = 8'hFF;
        wdata_d = req_wdata;
      end
    endcase
    sel_d  = SEL_WIDTH'(mask8) << off;
    addr_d = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ:   if (bus_ready) state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (bus_rvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // keep masks the loaded field; its top bit is the sign source for narrow loads.
  assign shifted  = bus_rdata >> {off_q, 3'b000};
  assign keep     = ~(ONES << (32'd8 << size_q));
  assign sign_bit = sign_q & (|(shifted & keep & ~(keep >> 1)));
  assign ext      = (shifted & keep) | (sign_bit ? ~keep : '0);
  assign capture  = (state_q == S_WAIT) & bus_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= 2'd0;
      off_q        <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_valid_q <= capture;
      if (capture) load_data_q <= ext;
      if (accept) begin
        we_q    <= req_write;
        sign_q  <= req_sign_ext;
        size_q  <= req_size;
        off_q   <= off;
        sel_q   <= sel_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
      end
    end
  end

  assign stall_req  = accept | (state_q == S_REQ) | (state_q == S_WAIT);
  assign bus_en     = (state_q == S_REQ);
  assign bus_we     = we_q;
  assign bus_sel    = sel_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 32-bit instance checked every cycle against a
// transaction-level model, plus directed checks on a 64-bit instance.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // 32-bit instance
  logic        req_valid = 0, req_read = 0, req_write = 0, req_sign_ext = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        stall_req, bus_en, bus_we, load_valid, addr_err_load, addr_err_store;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, load_data, bad_vaddr;
  logic        bus_ready = 0, bus_rvalid = 0;
  logic [31:0] bus_rdata = 0;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_sign_ext(req_sign_ext), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_req(stall_req),
    .bus_en(bus_en), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .load_valid(load_valid), .load_data(load_data),
    .addr_err_load(addr_err_load), .addr_err_store(addr_err_store), .bad_vaddr(bad_vaddr));

  // 64-bit instance
  logic        w_valid = 0, w_read = 0, w_write = 0, w_sign = 0;
  logic [1:0]  w_size = 0;
  logic [31:0] w_addr = 0;
  logic [63:0] w_wdata = 0;
  logic        w_stall, w_en, w_we, w_lv, w_errl, w_errs;
  logic [7:0]  w_sel;
  logic [31:0] w_baddr, w_bad;
  logic [63:0] w_bwdata, w_ldata;
  logic        w_ready = 0, w_rvalid = 0;
  logic [63:0] w_rdata = 0;

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(w_valid), .req_read(w_read),
    .req_write(w_write), .req_sign_ext(w_sign), .req_size(w_size),
    .req_addr(w_addr), .req_wdata(w_wdata), .stall_req(w_stall),
    .bus_en(w_en), .bus_we(w_we), .bus_sel(w_sel), .bus_addr(w_baddr),
    .bus_wdata(w_bwdata), .bus_ready(w_ready), .bus_rvalid(w_rvalid),
    .bus_rdata(w_rdata), .load_valid(w_lv), .load_data(w_ldata),
    .addr_err_load(w_errl), .addr_err_store(w_errs), .bad_vaddr(w_bad));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic model_aligned(input logic [63:0] addr, input logic [1:0] size, input int dw);
    int bytes = 1 << size;
    int lanes = dw / 8;
    if (bytes > lanes) return 1'b0;
    return ((addr % lanes) % bytes) == 0;
  endfunction

  function automatic logic [63:0] model_sel(input logic [63:0] addr, input logic [1:0] size, input int dw);
    int bytes = 1 << size;
    int o = int'(addr % (dw / 8));
    return ((64'd1 << bytes) - 64'd1) << o;
  endfunction

  function automatic logic [63:0] model_baddr(input logic [63:0] addr, input int dw);
    return addr - (addr % (dw / 8));
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [1:0] size, input int dw);
    int nb = 8 << size;
    logic [63:0] piece, r;
    piece = (nb == 64) ? wd : wd % (64'd1 << nb);
    r = 0;
    for (int k = 0; k < dw / nb; k++) r = r | (piece << (k * nb));
    return r;
  endfunction

  function automatic logic [63:0] model_extract(input logic [63:0] rdata, input logic [63:0] addr,
                                                input logic [1:0] size, input logic sgn, input int dw);
    int o = int'(addr % (dw / 8));
    int nb = 8 << size;
    logic [63:0] v;
    v = rdata >> (8 * o);
    if (nb < dw) begin
      v = v % (64'd1 << nb);
      if (sgn && v >= (64'd1 << (nb - 1))) v = v - (64'd1 << nb);
    end
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // ---------------- transaction model for the 32-bit instance ----------------
  logic        m_active = 0, m_accepted = 0, m_finished = 0, m_is_load = 0, m_write = 0, m_sign = 0;
  logic [1:0]  m_size = 0;
  logic [31:0] m_addr = 0, m_baddr = 0, m_wd = 0, m_ld = 0;
  logic [3:0]  m_sel = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_accepted = 0; m_finished = 0; m_is_load = 0; m_write = 0;
      m_sel = 0; m_baddr = 0; m_wd = 0; m_ld = 0;
    end else if (m_finished) begin
      m_finished = 0;
    end else if (!m_active) begin
      if (req_valid && (req_read || req_write) && model_aligned(64'(req_addr), req_size, 32)) begin
        m_active = 1; m_accepted = 0;
        m_write = req_write; m_sign = req_sign_ext; m_size = req_size; m_addr = req_addr;
        m_sel   = 4'(model_sel(64'(req_addr), req_size, 32));
        m_baddr = 32'(model_baddr(64'(req_addr), 32));
        m_wd    = 32'(model_wdata(64'(req_wdata), req_size, 32));
      end
    end else if (!m_accepted) begin
      if (bus_ready) begin
        if (m_write) begin
          m_active = 0; m_finished = 1; m_is_load = 0;
        end else begin
          m_accepted = 1;
        end
      end
    end else if (bus_rvalid) begin
      m_ld = 32'(model_extract(64'(bus_rdata), 64'(m_addr), m_size, m_sign, 32));
      m_active = 0; m_finished = 1; m_is_load = 1;
    end
  end

  logic chk_en = 0;
  logic c_idle, c_start, c_al, c_flt;
  always @(negedge clk) begin
    if (chk_en) begin
      c_idle  = !m_active && !m_finished;
      c_start = req_valid && (req_read || req_write);
      c_al    = model_aligned(64'(req_addr), req_size, 32);
      c_flt   = c_idle && c_start && !c_al;
      check("stall_req", 64'(stall_req), 64'((c_idle && c_start && c_al) || m_active));
      check("bus_en", 64'(bus_en), 64'(m_active && !m_accepted));
      check("bus_we", 64'(bus_we), 64'(m_write));
      check("bus_sel", 64'(bus_sel), 64'(m_sel));
      check("bus_addr", 64'(bus_addr), 64'(m_baddr));
      check("bus_wdata", 64'(bus_wdata), 64'(m_wd));
      check("load_valid", 64'(load_valid), 64'(m_finished && m_is_load));
      check("load_data", 64'(load_data), 64'(m_ld));
      check("addr_err_load", 64'(addr_err_load), 64'(c_flt && req_read));
      check("addr_err_store", 64'(addr_err_store), 64'(c_flt && req_write));
      check("bad_vaddr", 64'(bad_vaddr), c_flt ? 64'(req_addr) : 64'd0);
    end
  end

  // ---------------- transaction drivers ----------------
  task automatic run32(input logic rd, input logic wr, input logic sg, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int rdy_wait, input int rv_wait,
                       output int stall_cnt, output int lv_cycle, output int lv_cnt,
                       output logic [3:0] sel0, output logic [31:0] addr0, output logic [31:0] wd0,
                       output logic we0, output logic steady);
    int rdy_cnt, rv_cnt;
    logic in_wait, seen_en, fin, nr, nv;
    @(posedge clk); #1;
    req_valid = 1; req_read = rd; req_write = wr; req_sign_ext = sg; req_size = sz;
    req_addr = a; req_wdata = wd; bus_rdata = rdat; bus_ready = 0; bus_rvalid = 0;
    stall_cnt = 0; lv_cycle = -1; lv_cnt = 0; rdy_cnt = 0; rv_cnt = 0;
    in_wait = 0; seen_en = 0; fin = 0; steady = 1; sel0 = 0; addr0 = 0; wd0 = 0; we0 = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (stall_req) stall_cnt++;
      if (load_valid) begin lv_cnt++; lv_cycle = c; end
      if (bus_en) begin
        if (!seen_en) begin
          seen_en = 1; sel0 = bus_sel; addr0 = bus_addr; wd0 = bus_wdata; we0 = bus_we;
        end else if (bus_sel !== sel0 || bus_addr !== addr0 || bus_wdata !== wd0 || bus_we !== we0) begin
          steady = 0;
        end
      end
      nr = 0; nv = 0;
      if (bus_en) begin nr = (rdy_cnt >= rdy_wait); rdy_cnt++; end
      if (in_wait) begin nv = (rv_cnt >= rv_wait); rv_cnt++; end
      if (in_wait && nv) in_wait = 0;
      if (bus_en && nr && rd) in_wait = 1;
      if (c > 0 && !stall_req) fin = 1;
      #1;
      bus_ready = nr; bus_rvalid = nv;
      if (fin) begin req_valid = 0; req_read = 0; req_write = 0; end
    end
    check("txn32_completes", 64'(fin), 64'd1);
    req_valid = 0; req_read = 0; req_write = 0; bus_ready = 0; bus_rvalid = 0;
  endtask

  task automatic run64(input logic rd, input logic wr, input logic sg, input logic [1:0] sz,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                       output int stall_cnt, output int lv_cnt,
                       output logic [7:0] sel0, output logic [31:0] addr0, output logic [63:0] wd0);
    logic in_wait, seen_en, fin, nr, nv;
    @(posedge clk); #1;
    w_valid = 1; w_read = rd; w_write = wr; w_sign = sg; w_size = sz;
    w_addr = a; w_wdata = wd; w_rdata = rdat; w_ready = 0; w_rvalid = 0;
    stall_cnt = 0; lv_cnt = 0; in_wait = 0; seen_en = 0; fin = 0; sel0 = 0; addr0 = 0; wd0 = 0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (w_stall) stall_cnt++;
      if (w_lv) lv_cnt++;
      if (w_en && !seen_en) begin seen_en = 1; sel0 = w_sel; addr0 = w_baddr; wd0 = w_bwdata; end
      nr = w_en;
      nv = in_wait;
      in_wait = w_en && rd;
      if (c > 0 && !w_stall) fin = 1;
      #1;
      w_ready = nr; w_rvalid = nv;
      if (fin) begin w_valid = 0; w_read = 0; w_write = 0; end
    end
    check("txn64_completes", 64'(fin), 64'd1);
    w_valid = 0; w_read = 0; w_write = 0; w_ready = 0; w_rvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int sc, lc, ln, sc64, ln64;
  logic [3:0]  s0;
  logic [31:0] a0, d0;
  logic        we0, stdy;
  logic [7:0]  s64;
  logic [31:0] a64;
  logic [63:0] d64;

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_bus_en", 64'(bus_en), 64'd0);
    check("rst_load_data", 64'(load_data), 64'd0);
    check("rst64_ldata", w_ldata, 64'd0);
    check("rst64_sel", 64'(w_sel), 64'd0);
    @(posedge clk); #1;
    rst = 0;

    // LB signed at 0x1003, immediate handshake
    run32(1, 0, 1, 2'd0, 32'h1003, 32'h0, 32'h8000_0000, 0, 0, sc, lc, ln, s0, a0, d0, we0, stdy);
    check("lb_sel", 64'(s0), 64'h8);
    check("lb_addr", 64'(a0), 64'h1000);
    check("lb_data", 64'(load_data), 64'hFFFF_FF80);
    check("lb_lv_cycle", 64'(lc), 64'd3);
    check("lb_stalls", 64'(sc), 64'd3);
    check("lb_lv_count", 64'(ln), 64'd1);

    // LHU at 0x2002
    run32(1, 0, 0, 2'd1, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0, sc, lc, ln, s0, a0, d0, we0, stdy);
    check("lhu_sel", 64'(s0), 64'hC);
    check("lhu_data", 64'(load_data), 64'h0000_BEEF);

    // SH at 0x3002 with bus_ready low for 3 cycles
    run32(0, 1, 0, 2'd1, 32'h3002, 32'h1234_ABCD, 32'h0, 3, 0, sc, lc, ln, s0, a0, d0, we0, stdy);
    check("sh_we", 64'(we0), 64'd1);
    check("sh_sel", 64'(s0), 64'hC);
    check("sh_wdata", 64'(d0), 64'hABCD_ABCD);
    check("sh_steady", 64'(stdy), 64'd1);
    check("sh_stalls", 64'(sc), 64'd5);
    check("sh_no_lv", 64'(ln), 64'd0);
    check("sh_keeps_load_data", 64'(load_data), 64'h0000_BEEF);

    // Misaligned LW, then misaligned SW, then dword on a 32-bit bus
    @(posedge clk); #1;
    req_valid = 1; req_read = 1; req_write = 0; req_size = 2'd2; req_addr = 32'h4002;
    @(negedge clk);
    check("lw_mis_err", 64'(addr_err_load), 64'd1);
    check("lw_mis_bad", 64'(bad_vaddr), 64'h4002);
    check("lw_mis_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    req_read = 0; req_write = 1; req_addr = 32'h4001;
    @(negedge clk);
    check("sw_mis_err", 64'(addr_err_store), 64'd1);
    check("sw_mis_errl", 64'(addr_err_load), 64'd0);
    check("sw_mis_bad", 64'(bad_vaddr), 64'h4001);
    check("sw_mis_en", 64'(bus_en), 64'd0);
    @(posedge clk); #1;
    req_read = 1; req_write = 0; req_size = 2'd3; req_addr = 32'h6000;
    @(negedge clk);
    check("ld32_err", 64'(addr_err_load), 64'd1);
    check("ld32_bad", 64'(bad_vaddr), 64'h6000);
    @(posedge clk); #1;
    req_valid = 0; req_read = 0;
    @(negedge clk);
    check("err_clear", 64'(addr_err_load), 64'd0);

    // Reset while waiting for read data; late rvalid must be ignored
    @(posedge clk); #1;
    req_valid = 1; req_read = 1; req_size = 2'd2; req_addr = 32'h5000; req_sign_ext = 0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_req_en", 64'(bus_en), 64'd1);
    #1; bus_ready = 1;
    @(negedge clk);
    check("rstw_wait_stall", 64'(stall_req), 64'd1);
    #1; bus_ready = 0; rst = 1; req_valid = 0; req_read = 0;
    @(negedge clk);
    check("rstw_stall", 64'(stall_req), 64'd0);
    check("rstw_sel", 64'(bus_sel), 64'd0);
    check("rstw_addr", 64'(bus_addr), 64'd0);
    check("rstw_wdata", 64'(bus_wdata), 64'd0);
    check("rstw_load_data", 64'(load_data), 64'd0);
    #1; rst = 0; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rstw_late_lv", 64'(load_valid), 64'd0);
    #1; bus_rvalid = 0;
    @(negedge clk);
    check("rstw_late_lv2", 64'(load_valid), 64'd0);
    check("rstw_late_data", 64'(load_data), 64'd0);

    // Normal traffic after reset
    run32(1, 0, 0, 2'd2, 32'h7000, 32'h0, 32'hCAFE_F00D, 0, 2, sc, lc, ln, s0, a0, d0, we0, stdy);
    check("lw_data", 64'(load_data), 64'hCAFE_F00D);
    check("lw_stalls", 64'(sc), 64'd5);
    check("lw_lv_cycle", 64'(lc), 64'd5);
    run32(0, 1, 0, 2'd0, 32'h8001, 32'h0000_00A5, 32'h0, 0, 0, sc, lc, ln, s0, a0, d0, we0, stdy);
    check("sb_sel", 64'(s0), 64'h2);
    check("sb_wdata", 64'(d0), 64'hA5A5_A5A5);
    check("sb_stalls", 64'(sc), 64'd2);
    run32(1, 0, 1, 2'd1, 32'h9000, 32'h0, 32'h1234_8001, 0, 0, sc, lc, ln, s0, a0, d0, we0, stdy);
    check("lh_data", 64'(load_data), 64'hFFFF_8001);

    // 64-bit bus
    run64(0, 1, 0, 2'd2, 32'h1004, 64'h1122_3344_AABB_CCDD, 64'h0, sc64, ln64, s64, a64, d64);
    check("w_sw_sel", 64'(s64), 64'hF0);
    check("w_sw_addr", 64'(a64), 64'h1000);
    check("w_sw_wdata", d64, 64'hAABB_CCDD_AABB_CCDD);
    check("w_sw_stalls", 64'(sc64), 64'd2);
    run64(1, 0, 1, 2'd3, 32'h2000, 64'h0, 64'h8000_0000_0000_0001, sc64, ln64, s64, a64, d64);
    check("w_ld_sel", 64'(s64), 64'hFF);
    check("w_ld_data", w_ldata, 64'h8000_0000_0000_0001);
    check("w_ld_lv", 64'(ln64), 64'd1);
    check("w_ld_stalls", 64'(sc64), 64'd3);
    run64(1, 0, 1, 2'd0, 32'h3007, 64'h0, 64'h8000_0000_0000_0000, sc64, ln64, s64, a64, d64);
    check("w_lb_data", w_ldata, 64'hFFFF_FFFF_FFFF_FF80);
    check("w_lb_model", w_ldata, model_extract(64'h8000_0000_0000_0000, 64'h3007, 2'd0, 1'b1, 64));
    run64(1, 0, 0, 2'd2, 32'h4004, 64'h0, 64'hF000_0000_1234_5678, sc64, ln64, s64, a64, d64);
    check("w_lwu_data", w_ldata, 64'h0000_0000_F000_0000);
    @(posedge clk); #1;
    w_valid = 1; w_read = 1; w_size = 2'd3; w_addr = 32'h5004;
    @(negedge clk);
    check("w_ld_mis_err", 64'(w_errl), 64'd1);
    check("w_ld_mis_bad", 64'(w_bad), 64'h5004);
    check("w_ld_mis_stall", 64'(w_stall), 64'd0);
    @(posedge clk); #1;
    w_valid = 0; w_read = 0;
    @(negedge clk);
    check("w_idle_en", 64'(w_en), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit in the MEM stage. It takes a decoded memory request (read/write, size, sign-extension, address, store data), checks alignment, and drives byte-lane-correct accesses onto a handshaked data-memory bus. It holds the pipeline until the access completes, then returns aligned, extended load data. It generalises the ID-stage memory control decode to any power-of-two data width and variable-latency memory.

## Interface
Parameters:
- DATA_WIDTH, 32, bus/register width; 32 or 64.
- ADDR_WIDTH, 32, byte-address width.
- SEL_WIDTH, DATA_WIDTH/8, byte-lane count; derived, never overridden.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage holds a memory instruction.
- req_read  in  1  load.
- req_write  in  1  store; never set together with req_read.
- req_sign_ext  in  1  sign-extend load result; otherwise zero-extend.
- req_size  in  2  log2 bytes: 0 byte, 1 half, 2 word, 3 dword (DATA_WIDTH=64 only).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- stall_req  out  1  pipeline hold request.
- bus_en  out  1  bus request valid.
- bus_we  out  1  write strobe.
- bus_sel  out  SEL_WIDTH  byte-lane enables.
- bus_addr  out  ADDR_WIDTH  address aligned to DATA_WIDTH.
- bus_wdata  out  DATA_WIDTH  lane-replicated store data.
- bus_ready  in  1  bus accepts the request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  DATA_WIDTH  raw read word.
- load_valid  out  1  one-cycle pulse; load_data updated.
- load_data  out  DATA_WIDTH  aligned, extended load result.
- addr_err_load  out  1  misaligned or unsupported load.
- addr_err_store  out  1  misaligned or unsupported store.
- bad_vaddr  out  ADDR_WIDTH  faulting address.

## Operation
- Definitions:
  - `start` = req_valid & (req_read | req_write).
  - `off` = req_addr[log2(SEL_WIDTH)-1:0].
  - A request is `misaligned` when off is not a multiple of 2^req_size, or when 2^req_size > SEL_WIDTH.
- Error path: `start` & misaligned raises addr_err_load or addr_err_store combinationally in the same cycle and drives bad_vaddr = req_addr. No bus activity occurs, stall_req stays 0, and the state stays IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on `start` & aligned, latch the request and go to REQ.
  - REQ: bus_en=1. On bus_ready, a store goes to DONE and a load goes to WAIT.
  - WAIT: on bus_rvalid, capture load data and go to DONE.
  - DONE: always go to IDLE; req_* inputs are ignored.
- Bus fields are registered from the latched request and held stable for the whole REQ state:
  - bus_sel = ((1 << 2^size) - 1) << off.
  - bus_addr = req_addr with its low log2(SEL_WIDTH) bits cleared.
  - bus_wdata = low 8·2^size bits of req_wdata, replicated across DATA_WIDTH.
  - bus_we = latched req_write.
- Load extraction: shift bus_rdata right by 8·off, keep the low 8·2^size bits, then sign- or zero-extend to DATA_WIDTH. Bit DATA_WIDTH-1 is the sign source only for a full-width load.
- load_data holds its value until the next load completes.
- stall_req = (IDLE & `start` & aligned) | REQ | WAIT. It is 0 in DONE, so the pipeline advances at the end of DONE.
- bus_rvalid outside WAIT is ignored. bus_ready outside REQ is ignored.

## Timing
- Reset: state IDLE. stall_req, bus_en, bus_we, load_valid, addr_err_* all 0. bus_sel, bus_addr, bus_wdata, load_data, bad_vaddr all 0.
- Reset mid-transaction abandons it; no load_valid pulse follows. A late bus_rvalid arrives in IDLE and is ignored.
- Minimum load (ready in first REQ cycle, rvalid the next): accept in cycle 0, REQ in cycle 1, WAIT in cycle 2, DONE with load_valid in cycle 3. stall_req is high in cycles 0-2.
- Minimum store: accept in cycle 0, REQ in cycle 1, DONE in cycle 2. stall_req is high in cycles 0-1.
- Each cycle that bus_ready is low in REQ, or bus_rvalid is low in WAIT, adds one stall cycle.
- bus_rvalid is never expected in the same cycle as bus_ready.
- addr_err_* and bad_vaddr are combinational and have zero latency. If a DONE-cycle input would fault, the fault is suppressed (inputs are ignored in DONE).

## Test plan
- DATA_WIDTH=32, LB signed at 0x1003, rdata 0x80000000, immediate ready/rvalid -> bus_sel 4'b1000, bus_addr 0x1000, load_data 0xFFFFFF80, load_valid in cycle 3, 3 stall cycles.
- LHU at 0x2002, rdata 0xBEEF1234 -> bus_sel 4'b1100, load_data 0x0000BEEF.
- SH at 0x3002, wdata 0x1234ABCD, bus_ready held low 3 cycles -> bus_we=1, bus_sel 4'b1100, bus_wdata 0xABCDABCD stable throughout, stall_req high for 5 cycles, no load_valid.
- LW at 0x4002, then SW at 0x4001 -> addr_err_load=1 then addr_err_store=1, bad_vaddr 0x4002 then 0x4001, bus_en never set, stall_req 0.
- rst asserted in WAIT, bus_rvalid one cycle later -> all outputs at reset values, load_valid stays 0, next request accepted normally.
- DATA_WIDTH=64: SW at 0x...4 -> bus_sel 8'hF0; LD at 0x...0, rdata 0x8000_0000_0000_0001 signed -> load_data equals rdata; size 3 with DATA_WIDTH=32 -> addr error.
